mic_level_meter: RTL and testbench

//  Producer of the 16-bit thermometer volume level consumed by the OLED soundbar renderers.

---
 rtl/mic_level_meter_pkg.sv | 17 +
 rtl/mic_level_meter_if.sv | 17 +
 rtl/mic_level_meter_quantiser.sv | 18 +
 rtl/mic_level_meter.sv | 87 ++++++++
 tb/tb_mic_level_meter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mic_level_meter_pkg.sv
// Shared widths and helpers for the microphone level meter.
// The thermometer encoder lives here so the RTL and any consumer build level codes the same way.
package mic_level_meter_pkg;
  localparam int BAR_COUNT = 16;
  localparam int LEVEL_W   = 16;
  localparam int MIC_W     = 12;
  localparam int AMP_W     = 11;
  localparam int BARS_W    = 5;

  // Bit k is lit when k < bars, so bars=16 gives all ones.
  function automatic logic [LEVEL_W-1:0] thermometer(input logic [BARS_W-1:0] bars);
    logic [LEVEL_W-1:0] t;
    t = '0;
    for (int k = 0; k < LEVEL_W; k++) t[k] = (BARS_W'(k) < bars);
    return t;
  endfunction
endpackage

// File: rtl/mic_level_meter_if.sv
// Sample stream in, level/bars/peak out; the master side is the mic/display environment.
interface mic_level_meter_if;
  import mic_level_meter_pkg::*;

  logic               sample_en;
  logic [MIC_W-1:0]   mic_in;
  logic               freeze;
  logic [LEVEL_W-1:0] level;
  logic [BARS_W-1:0]  bars;
  logic [AMP_W-1:0]   peak;
  logic               level_valid;

  modport master (output sample_en, mic_in, freeze,
                  input  level, bars, peak, level_valid);
  modport slave  (input  sample_en, mic_in, freeze,
                  output level, bars, peak, level_valid);
endinterface

// File: rtl/mic_level_meter_quantiser.sv
// Amplitude to bar count: counts how many of the thresholds STEP, 2*STEP .. 16*STEP are reached.
module level_quantiser
  import mic_level_meter_pkg::*;
#(
  parameter int STEP = 120
) (
  input  logic [AMP_W-1:0]  i_amp,
  output logic [BARS_W-1:0] o_bars
);

  always_comb begin
    o_bars = '0;
    for (int k = 1; k <= BAR_COUNT; k++) begin
      if (32'(i_amp) >= 32'(k * STEP)) o_bars = o_bars + BARS_W'(1);
    end
  end

endmodule

// File: rtl/mic_level_meter.sv
// Windowed peak meter: tracks peak amplitude per WINDOW samples and publishes a decaying bar level.
module mic_level_meter
  import mic_level_meter_pkg::*;
#(
  parameter int WINDOW   = 2000,
  parameter int BASELINE = 2048,
  parameter int STEP     = 120,
  parameter int DECAY_EN = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  mic_level_meter_if.slave  io_mic
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [MIC_W:0] BASE    = (MIC_W+1)'(BASELINE);
  localparam logic [MIC_W:0] AMP_MAX = (MIC_W+1)'(2**AMP_W - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [AMP_W-1:0]   r_acc;
  logic [AMP_W-1:0]   r_peak;
  logic [BARS_W-1:0]  r_bars;
  logic [LEVEL_W-1:0] r_level;
  logic               r_valid;

  logic [MIC_W:0]     w_diff;
  logic [AMP_W-1:0]   w_amp;
  logic [AMP_W-1:0]   w_win_peak;
  logic [BARS_W-1:0]  w_new_bars;
  logic [BARS_W-1:0]  w_next_bars;
  logic               w_close;

  always_comb begin
    w_diff = {1'b0, io_mic.mic_in} - BASE;
    w_amp  = '0;
    if ({1'b0, io_mic.mic_in} > BASE) begin
      w_amp = (w_diff > AMP_MAX) ? AMP_MAX[AMP_W-1:0] : w_diff[AMP_W-1:0];
    end
  end

  // The closing sample is part of the window it closes.
  assign w_win_peak = (w_amp > r_acc) ? w_amp : r_acc;
  assign w_close    = io_mic.sample_en && (r_cnt == CNT_W'(WINDOW - 1));

  level_quantiser #(.STEP(STEP)) u_quant (
    .i_amp  (w_win_peak),
    .o_bars (w_new_bars)
  );

  // Instant attack; with decay enabled a quieter window drops the display by one bar only.
  always_comb begin
    w_next_bars = w_new_bars;
    if (DECAY_EN != 0 && w_new_bars < r_bars) w_next_bars = r_bars - BARS_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_peak  <= '0;
      r_bars  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_close) begin
        r_cnt <= '0;
        r_acc <= '0;
        if (!io_mic.freeze) begin
          r_peak  <= w_win_peak;
          r_bars  <= w_next_bars;
          r_level <= thermometer(w_next_bars);
          r_valid <= 1'b1;
        end
      end else if (io_mic.sample_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_win_peak;
      end
    end
  end

  assign io_mic.level       = r_level;
  assign io_mic.bars        = r_bars;
  assign io_mic.peak        = r_peak;
  assign io_mic.level_valid = r_valid;

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed bench for mic_level_meter: a reference model queues expected updates, a monitor pops them on level_valid.
module tb_mic_level_meter;

  typedef struct {
    logic [15:0] level;
    logic [4:0]  bars;
    logic [10:0] peak;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  exp_t q[$];
  exp_t disp;

  int m_cnt, m_acc, m_bars;

  mic_level_meter_if u_if ();

  mic_level_meter u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_mic (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int thermo(input int b);
    return (1 << b) - 1;
  endfunction

  // Between pulses the outputs must hold; on a pulse they must match the oldest queued update.
  always @(negedge clk) begin
    if (mon_en) begin
      if (u_if.level_valid === 1'b1) begin
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_valid observed 1 expected 0");
        end
        if (q.size() > 0) disp = q.pop_front();
      end
      chk("mon_level", 32'(u_if.level), 32'(disp.level));
      chk("mon_bars",  32'(u_if.bars),  32'(disp.bars));
      chk("mon_peak",  32'(u_if.peak),  32'(disp.peak));
    end
  end

  task automatic model_reset();
    m_cnt  = 0;
    m_acc  = 0;
    m_bars = 0;
    q.delete();
    disp.level = '0;
    disp.bars  = '0;
    disp.peak  = '0;
  endtask

  task automatic send(input int mic);
    int   amp, wp, nb;
    exp_t e;
    @(negedge clk);
    u_if.sample_en = 1'b1;
    u_if.mic_in    = 12'(mic);
    amp = (mic > 2048) ? mic - 2048 : 0;
    if (amp > 2047) amp = 2047;
    wp = (amp > m_acc) ? amp : m_acc;
    if (m_cnt == 1999) begin
      m_cnt = 0;
      m_acc = 0;
      if (!u_if.freeze) begin
        nb = wp / 120;
        if (nb > 16) nb = 16;
        m_bars  = (nb >= m_bars) ? nb : m_bars - 1;
        e.level = 16'(thermo(m_bars));
        e.bars  = 5'(m_bars);
        e.peak  = 11'(wp);
        q.push_back(e);
      end
    end else begin
      m_cnt++;
      m_acc = wp;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    u_if.sample_en = 1'b0;
  endtask

  task automatic window(input int base, input int special, input int idx, input bit gaps);
    for (int i = 0; i < 2000; i++) begin
      send((i == idx) ? special : base);
      if (gaps) idle();
    end
    idle();
    idle();
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL missing_valid observed %0d expected 0", q.size());
    end
  endtask

  initial begin
    rst            = 1'b0;
    u_if.sample_en = 1'b0;
    u_if.mic_in    = 12'd2048;
    u_if.freeze    = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_level", 32'(u_if.level), 32'h0);
    chk("reset_valid", 32'(u_if.level_valid), 32'h0);

    window(2048, 2048, 0, 1'b0);
    chk("silence_level", 32'(u_if.level), 32'h0000);
    chk("silence_peak",  32'(u_if.peak),  32'd0);

    window(2048, 4095, 777, 1'b0);
    chk("full_level", 32'(u_if.level), 32'hFFFF);
    chk("full_bars",  32'(u_if.bars),  32'd16);
    chk("full_peak",  32'(u_if.peak),  32'd2047);

    window(2048, 2048, 0, 1'b0);
    chk("decay1_level", 32'(u_if.level), 32'h7FFF);
    window(2048, 2048, 0, 1'b0);
    chk("decay2_level", 32'(u_if.level), 32'h3FFF);
    window(2048, 2048, 0, 1'b0);
    chk("decay3_level", 32'(u_if.level), 32'h1FFF);

    // Abort a window part way through with an asynchronous reset.
    for (int i = 0; i < 700; i++) send(2548);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_level", 32'(u_if.level), 32'h0);
    chk("async_bars",  32'(u_if.bars),  32'h0);
    chk("async_peak",  32'(u_if.peak),  32'h0);
    chk("async_valid", 32'(u_if.level_valid), 32'h0);
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    window(2048, 2348, 5, 1'b0);
    chk("amp300_level", 32'(u_if.level), 32'h0003);

    window(2048, 2648, 1000, 1'b0);
    chk("attack_level", 32'(u_if.level), 32'h001F);
    chk("attack_bars",  32'(u_if.bars),  32'd5);

    window(2048, 3048, 1999, 1'b0);
    chk("closing_bars", 32'(u_if.bars), 32'd8);
    chk("closing_peak", 32'(u_if.peak), 32'd1000);

    u_if.freeze = 1'b1;
    window(2048, 4095, 1500, 1'b0);
    u_if.freeze = 1'b0;
    chk("freeze_level", 32'(u_if.level), 32'h00FF);
    chk("freeze_peak",  32'(u_if.peak),  32'd1000);

    window(2048, 2048, 0, 1'b0);
    chk("unfreeze_level", 32'(u_if.level), 32'h007F);

    window(1000, 1000, 0, 1'b1);
    chk("below_base_level", 32'(u_if.level), 32'h003F);
    chk("below_base_peak",  32'(u_if.peak),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
